// File: rtl/axi_pkg.sv
// Shared AXI read-master definitions: bus widths, burst/size/response codes and the
// read-master state encoding reused by both the instruction- and data-side masters.
`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH
`define AXI_ADDR_BITS 32
`define AXI_DATA_BITS 32
`endif

package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        sIDLE = 2'd0,
        sADDR = 2'd1,
        sDATA = 2'd2
    } axi_rd_state_e;

endpackage

// File: rtl/cache_im_axi_read_master.sv
// Instruction-cache line-fill master: turns a one-cycle miss request into a single
// INCR burst on AXI AR/R, forwards beats combinationally and flags protocol anomalies.
module cache_im_axi_read_master
    import axi_pkg::*;
#(
    parameter int ID_WIDTH    = 4,
    parameter int AR_ID       = 0,
    parameter int BURST_BEATS = 4
) (
    input  logic                       clk,
    input  logic                       rstn,

    input  logic                       ARvalid,
    input  logic [`AXI_ADDR_BITS-1:0]  read_addr_M,
    output logic                       read_data_valid_M,
    output logic [`AXI_DATA_BITS-1:0]  read_data_M,
    output logic                       Rlast,
    output logic                       busy,
    output logic                       protocol_err,

    output logic [ID_WIDTH-1:0]        ARID_M,
    output logic [`AXI_ADDR_BITS-1:0]  ARADDR_M,
    output logic [3:0]                 ARLEN_M,
    output logic [2:0]                 ARSIZE_M,
    output logic [1:0]                 ARBURST_M,
    output logic                       ARVALID_M,
    input  logic                       ARREADY_M,

    input  logic [ID_WIDTH-1:0]        RID_M,
    input  logic [`AXI_DATA_BITS-1:0]  RDATA_M,
    input  logic [1:0]                 RRESP_M,
    input  logic                       RLAST_M,
    input  logic                       RVALID_M,
    output logic                       RREADY_M
);

    localparam logic [1:0]          LAST_IDX = 2'(BURST_BEATS - 1);
    localparam logic [ID_WIDTH-1:0] EXP_ID   = ID_WIDTH'(AR_ID);

    axi_rd_state_e               state, state_nxt;
    logic [`AXI_ADDR_BITS-1:0]   addr_reg;
    logic [1:0]                  beat_cnt;
    logic                        ar_hs;
    logic                        beat_acc;
    logic                        beat_bad;

    // Low nibble is dropped because requests are always line aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^read_addr_M[3:0];

    assign ARID_M    = EXP_ID;
    assign ARLEN_M   = 4'(BURST_BEATS - 1);
    assign ARSIZE_M  = SIZE_4B;
    assign ARBURST_M = BURST_INCR;
    assign ARADDR_M  = addr_reg;

    assign ar_hs    = ARVALID_M & ARREADY_M;
    assign beat_acc = RVALID_M & RREADY_M;

    assign read_data_valid_M = beat_acc;
    assign read_data_M       = RDATA_M;
    assign Rlast             = beat_acc & RLAST_M;

    // Anomalies are recorded but never alter sequencing; only RLAST ends the burst.
    assign beat_bad = (RRESP_M != OKAY)
                    | (RID_M != EXP_ID)
                    | ( RLAST_M & (beat_cnt != LAST_IDX))
                    | (~RLAST_M & (beat_cnt == LAST_IDX));

    always_comb begin
        state_nxt = state;
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            sIDLE: begin
                busy = 1'b0;
                if (ARvalid) state_nxt = sADDR;
            end
            sADDR: begin
                ARVALID_M = 1'b1;
                if (ARREADY_M) state_nxt = sDATA;
            end
            sDATA: begin
                RREADY_M = 1'b1;
                if (RVALID_M && RLAST_M) state_nxt = sIDLE;
            end
            default: state_nxt = sIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= sIDLE;
            addr_reg     <= '0;
            beat_cnt     <= 2'd0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == sIDLE && ARvalid)
                addr_reg <= {read_addr_M[`AXI_ADDR_BITS-1:4], 4'b0000};
            if (ar_hs)
                beat_cnt <= 2'd0;
            else if (beat_acc)
                beat_cnt <= beat_cnt + 2'd1;
            if (beat_acc && beat_bad)
                protocol_err <= 1'b1;
        end
    end

endmodule
